// File: rtl/hs_tmds_pkg.sv
// hs_tmds_pkg: shared definitions for the TMDS lane encoder.
//   PERIOD_DEF  default clocks per word slot
//   CNT_W_DEF   default width of the signed running-disparity counter
//   disp_t      signed running-disparity type
//   TOK_CTRL*   the four 10-bit control tokens
//   popcount8   number of ones in a byte
//   ctrl_token  ctrl select -> control token
package hs_tmds_pkg;

  localparam int PERIOD_DEF = 11;
  localparam int CNT_W_DEF  = 6;

  typedef logic signed [CNT_W_DEF-1:0] disp_t;

  localparam logic [9:0] TOK_CTRL0 = 10'h354;
  localparam logic [9:0] TOK_CTRL1 = 10'h0AB;
  localparam logic [9:0] TOK_CTRL2 = 10'h154;
  localparam logic [9:0] TOK_CTRL3 = 10'h2AB;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOK_CTRL0;
      2'b01:   t = TOK_CTRL1;
      2'b10:   t = TOK_CTRL2;
      default: t = TOK_CTRL3;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/hs_tmds_enc_if.sv
// hs_tmds_enc_if: word-slot bus between the pixel source, the encoder and
// the lane serializer.
//   data_in      pixel byte, consumed in the data_ready cycle
//   de           1 = encode data_in, 0 = send control token
//   ctrl         control token select
//   data_ready   one-cycle pulse, inputs consumed in this cycle
//   parallel_out encoded 10-bit word, bit 0 transmitted first
//   load_enable  one-cycle pulse, parallel_out valid and stable
// Modports: slave = encoder side, master = source/serializer side.
interface hs_tmds_enc_if;

  logic [7:0] data_in;
  logic       de;
  logic [1:0] ctrl;
  logic       data_ready;
  logic [9:0] parallel_out;
  logic       load_enable;

  modport slave (
    input  data_in, de, ctrl,
    output data_ready, parallel_out, load_enable
  );

  modport master (
    output data_in, de, ctrl,
    input  data_ready, parallel_out, load_enable
  );

endinterface

// File: rtl/hs_tmds_qm.sv
// hs_tmds_qm: combinational transition-minimisation stage.
//   data_in  in  8  pixel byte
//   q_m      out 9  XOR/XNOR chained byte, q_m[8]=1 when the XOR chain is used
module hs_tmds_qm
  import hs_tmds_pkg::*;
(
  input  logic [7:0] data_in,
  output logic [8:0] q_m
);

  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    // Ones-heavy bytes (and balanced bytes starting with 0) use XNOR so the
    // chain produces fewer transitions.
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  assign q_m = minimise(data_in);

endmodule

// File: rtl/hs_tmds_enc.sv
// hs_tmds_enc: TMDS 8b/10b encoder and word-rate timer for one lane.
//   clk  in  system clock
//   rst  in  asynchronous reset, active-high
//   bus  slave modport of hs_tmds_enc_if (data_in/de/ctrl in,
//        data_ready/parallel_out/load_enable out)
// Parameters: PERIOD clocks per word slot (4..63); CNT_W disparity width.
// Build option: HS_TMDS_DISPARITY_EN enables the running-disparity counter
// and DC-balancing inversion; without it data words are {0, q_m[8:0]}.
// Timing: data_ready at bit_cnt==PERIOD-3, S1 latch, S2 encode,
// load_enable at bit_cnt==PERIOD-1.
module hs_tmds_enc
  import hs_tmds_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF
`ifdef HS_TMDS_DISPARITY_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst,
  hs_tmds_enc_if.slave  bus
);

  localparam logic [5:0] CNT_LAST = 6'(PERIOD - 1);
  localparam logic [5:0] CNT_PRE  = 6'(PERIOD - 2);
  localparam logic [5:0] CNT_RDY  = 6'(PERIOD - 3);

  logic [5:0] bit_cnt;
  logic       load_en_q;
  logic [9:0] word_q;
  logic [9:0] word_nxt;
  logic [8:0] q_m;
  logic       s1_de;
  logic [1:0] s1_ctrl;
  logic [8:0] s1_qm;

  hs_tmds_qm u_qm (
    .data_in (bus.data_in),
    .q_m     (q_m)
  );

  assign bus.data_ready   = (bit_cnt == CNT_RDY);
  assign bus.load_enable  = load_en_q;
  assign bus.parallel_out = word_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      load_en_q <= 1'b0;
    end else begin
      bit_cnt   <= (bit_cnt == CNT_LAST) ? 6'd0 : bit_cnt + 6'd1;
      // Registered so the pulse lines up exactly with bit_cnt==PERIOD-1.
      load_en_q <= (bit_cnt == CNT_PRE);
    end
  end

  // S1: capture the slot's inputs at the edge that ends data_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_de   <= 1'b0;
      s1_ctrl <= '0;
      s1_qm   <= '0;
    end else if (bus.data_ready) begin
      s1_de   <= bus.de;
      s1_ctrl <= bus.ctrl;
      s1_qm   <= q_m;
    end
  end

`ifdef HS_TMDS_DISPARITY_EN
  typedef logic signed [CNT_W-1:0] cnt_t;

  cnt_t       cnt;
  cnt_t       cnt_nxt;
  cnt_t       n1;
  cnt_t       n0;
  cnt_t       diff;
  logic       q8;
  logic [7:0] qb;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    q8       = s1_qm[8];
    qb       = s1_qm[7:0];
    n1       = cnt_t'(popcount8(qb));
    n0       = cnt_t'(8) - n1;
    diff     = n1 - n0;
    word_nxt = ctrl_token(s1_ctrl);
    cnt_nxt  = '0;
    if (s1_de) begin
      if ((cnt == 0) || (diff == 0)) begin
        word_nxt = {~q8, q8, q8 ? qb : ~qb};
        cnt_nxt  = cnt + (q8 ? diff : -diff);
      end else if (((cnt > 0) && (n1 > n0)) || ((cnt < 0) && (n0 > n1))) begin
        // Inverting moves the running disparity back towards zero.
        word_nxt = {1'b1, q8, ~qb};
        cnt_nxt  = cnt + (q8 ? cnt_t'(2) : cnt_t'(0)) - diff;
      end else begin
        word_nxt = {1'b0, q8, qb};
        cnt_nxt  = cnt - (q8 ? cnt_t'(0) : cnt_t'(2)) + diff;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (bit_cnt == CNT_PRE) cnt <= cnt_nxt;
  end
`else
  always_comb begin
    word_nxt = s1_de ? {1'b0, s1_qm} : ctrl_token(s1_ctrl);
  end
`endif

  // S2: the word changes only at this edge and holds until the next slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    word_q <= '0;
    else if (bit_cnt == CNT_PRE) word_q <= word_nxt;
  end

endmodule

// File: tb/tb_hs_tmds_enc.sv
// tb_hs_tmds_enc: randomized self-checking bench for hs_tmds_enc with a
// slot-level reference model; directed slots carry literal expected words.
module tb_hs_tmds_enc;

  localparam int P = 11;

  typedef struct {
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    bit         has_gold;
    logic [9:0] gold;
    bit         has_gcnt;
    int         gcnt;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hs_tmds_enc_if bus ();

  hs_tmds_enc #(.PERIOD(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         k     = 0;
  int         mcnt  = 0;
  logic [9:0] held  = '0;
  logic [9:0] pend_word = '0;
  bit         pend_gold_v = 0;
  logic [9:0] pend_gold = '0;
  bit         pend_gcnt_v = 0;
  int         pend_gcnt = 0;
  int         pend_cnt  = 0;
  stim_t      stim_q[$];
  logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Slot-level reference: transition minimisation then DC balance rules.
  function automatic logic [9:0] model_word(input logic de, input logic [1:0] ctrl,
                                            input logic [7:0] d);
    int         n1, ones, zeros;
    logic       xn, q8;
    logic [8:0] qm;
    logic [9:0] w;
    if (!de) begin
      mcnt = 0;
      return tok[ctrl];
    end
    n1    = $countones(d);
    xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    q8    = qm[8];
`ifdef HS_TMDS_DISPARITY_EN
    ones  = $countones(qm[7:0]);
    zeros = 8 - ones;
    if (mcnt == 0 || ones == zeros) begin
      w    = {~q8, q8, q8 ? qm[7:0] : ~qm[7:0]};
      mcnt = mcnt + (q8 ? ones - zeros : zeros - ones);
    end else if ((mcnt > 0 && ones > zeros) || (mcnt < 0 && zeros > ones)) begin
      w    = {1'b1, q8, ~qm[7:0]};
      mcnt = mcnt + (q8 ? 2 : 0) + zeros - ones;
    end else begin
      w    = {1'b0, q8, qm[7:0]};
      mcnt = mcnt - (q8 ? 0 : 2) + ones - zeros;
    end
`else
    ones  = 0;
    zeros = 0;
    w     = {1'b0, qm};
`endif
    return w;
  endfunction

  task automatic drive_random();
    bus.de      = ($urandom_range(0, 3) != 0);
    bus.ctrl    = 2'($urandom);
    bus.data_in = 8'($urandom);
  endtask

  // One clock: check the cycle at its negedge, then drive the inputs that
  // the following posedge samples.
  task automatic step();
    stim_t s;
    int    ph;
    ph = -1;
    @(negedge clk);
    if (rst) begin
      check("rst_data_ready", 16'(bus.data_ready), 16'd0);
      check("rst_load_enable", 16'(bus.load_enable), 16'd0);
      check("rst_parallel_out", 16'(bus.parallel_out), 16'd0);
    end else begin
      ph = k % P;
      check("data_ready", 16'(bus.data_ready), 16'(ph == P - 3));
      check("load_enable", 16'(bus.load_enable), 16'(ph == P - 1));
      if (ph == P - 1) begin
        held = pend_word;
        if (pend_gold_v) check("golden_word", 16'(bus.parallel_out), 16'(pend_gold));
`ifdef HS_TMDS_DISPARITY_EN
        check("disparity", 16'(dut.cnt), 16'(pend_cnt));
        if (pend_gcnt_v) check("golden_cnt", 16'(dut.cnt), 16'(pend_gcnt));
`endif
        pend_gold_v = 0;
        pend_gcnt_v = 0;
      end
      check("parallel_out", 16'(bus.parallel_out), 16'(held));
    end
    if (!rst && ph == P - 3) begin
      if (stim_q.size() > 0) begin
        s           = stim_q.pop_front();
        bus.de      = s.de;
        bus.ctrl    = s.ctrl;
        bus.data_in = s.data;
        pend_gold_v = s.has_gold;
        pend_gold   = s.gold;
        pend_gcnt_v = s.has_gcnt;
        pend_gcnt   = s.gcnt;
      end else begin
        drive_random();
        pend_gold_v = 0;
        pend_gcnt_v = 0;
      end
      pend_word = model_word(bus.de, bus.ctrl, bus.data_in);
      pend_cnt  = mcnt;
    end else begin
      drive_random();
    end
    if (!rst) k++;
  endtask

  task automatic push(input logic de, input logic [1:0] ctrl, input logic [7:0] data,
                      input bit has_gold, input logic [9:0] gold,
                      input bit has_gcnt, input int gcnt);
    stim_t s;
    s.de = de; s.ctrl = ctrl; s.data = data;
    s.has_gold = has_gold; s.gold = gold;
    s.has_gcnt = has_gcnt; s.gcnt = gcnt;
    stim_q.push_back(s);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (stim_q.size() > 0 && guard < 20 * P) begin
      step();
      guard++;
    end
    check("drain_bound", 16'(stim_q.size()), 16'd0);
    repeat (P) step();
  endtask

  initial begin
    int guard;
    bus.data_in = '0;
    bus.de      = 1'b0;
    bus.ctrl    = '0;

    // Reset, then release on a negedge: next observed cycle has bit_cnt=1.
    repeat (3) step();
    rst = 1'b0;
    k   = 1;

    // Control tokens in successive slots; the first load carries 10'h354.
    for (int c = 0; c < 4; c++)
      push(1'b0, 2'(c), 8'($urandom), 1'b1, tok[c], 1'b1, 0);

    // DC balance run of zero bytes, then a token clears the disparity.
`ifdef HS_TMDS_DISPARITY_EN
    push(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, 1'b1, -8);
    push(1'b1, 2'd0, 8'h00, 1'b1, 10'h3FF, 1'b1,  2);
    push(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, 1'b1, -6);
    push(1'b0, 2'd0, 8'h5A, 1'b1, 10'h354, 1'b1,  0);
    push(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, 1'b1, -8);
`else
    push(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, 1'b0, 0);
    push(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, 1'b0, 0);
    push(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, 1'b0, 0);
    push(1'b0, 2'd0, 8'h5A, 1'b1, 10'h354, 1'b0, 0);
    push(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, 1'b0, 0);
`endif
    drain();

    // Random slots against the reference model.
    repeat (40 * P) step();

    // Mid-word reset while a data word sits in S1 (bit_cnt==PERIOD-2).
    push(1'b1, 2'd0, 8'hA5, 1'b0, 10'h000, 1'b0, 0);
    guard = 0;
    while (!(stim_q.size() == 0 && (k % P) == P - 1) && guard < 3 * P) begin
      step();
      guard++;
    end
    check("midrst_reach", 16'(guard < 3 * P), 16'd1);
    rst = 1'b1;
    #1;
    check("midrst_data_ready", 16'(bus.data_ready), 16'd0);
    check("midrst_load_enable", 16'(bus.load_enable), 16'd0);
    check("midrst_parallel_out", 16'(bus.parallel_out), 16'd0);
    mcnt        = 0;
    held        = '0;
    pend_gold_v = 0;
    pend_gcnt_v = 0;
    repeat (2) step();
    rst = 1'b0;
    k   = 1;
    push(1'b0, 2'd2, 8'h00, 1'b1, 10'h154, 1'b1, 0);
`ifdef HS_TMDS_DISPARITY_EN
    push(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, 1'b1, -8);
`else
    push(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, 1'b0, 0);
`endif
    drain();
    repeat (10 * P) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
